round_controller: RTL

- Game-side driver for the scoring interface. It generates a pseudo-random nibble (RN) from a free-running LFSR and shows it to the player.
- It captures the player's nibble and forms the 4-bit sum RN + player. It then issues the LoadPlayer/LoadRN handshake consumed by the verification/score block.
- It sits between the button/switch conditioning logic and the scorer. A round is a hit when sum == 4'b1111.

---
 rtl/round_controller_if.sv | 32 +++
 rtl/round_controller.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/round_controller_if.sv
// Player/scorer signal bundle for round_controller.
//   master : the round controller (consumes player inputs, drives scorer outputs)
//   slave  : the environment (switches/buttons and the scoring block)
// Signals:
//   PlayerIn    [3:0] player nibble from switches
//   PlayerBtn         submit button, level
//   NextBtn           new-number button, level
//   RN          [3:0] current random nibble for display
//   sum         [3:0] RN + PlayerIn modulo 16
//   LoadPlayer        one-cycle pulse, sum valid
//   LoadRN            one-cycle pulse, new RN
//   RoundActive       high while waiting for the player's entry
interface round_controller_if;
  logic [3:0] PlayerIn;
  logic       PlayerBtn;
  logic       NextBtn;
  logic [3:0] RN;
  logic [3:0] sum;
  logic       LoadPlayer;
  logic       LoadRN;
  logic       RoundActive;

  modport master (
    input  PlayerIn, PlayerBtn, NextBtn,
    output RN, sum, LoadPlayer, LoadRN, RoundActive
  );

  modport slave (
    output PlayerIn, PlayerBtn, NextBtn,
    input  RN, sum, LoadPlayer, LoadRN, RoundActive
  );
endinterface

// File: rtl/round_controller.sv
// Game-side round driver for the scoring block. Shows a pseudo-random nibble taken from a
// free-running 8-bit LFSR, captures the player's nibble, and hands RN + player to the scorer
// with LoadRN / LoadPlayer pulses. A guard period after each LoadPlayer keeps LoadRN quiet
// until the scorer has settled.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous, active-low reset
//   bus  round_controller_if.master (PlayerIn, PlayerBtn, NextBtn in; RN, sum, LoadPlayer,
//        LoadRN, RoundActive out)
// Build option:
//   ROUND_TIMEOUT_EN  when defined, an unanswered round is closed as a miss (sum = 0) after
//                     TIMEOUT_CYCLES clocks in ARMED.
module round_controller #(
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int unsigned GUARD_CYCLES   = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input logic                clk,
  input logic                rst,
  round_controller_if.master bus
);

  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StSettle, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              pbtn_q, nbtn_q;
  logic              pbtn_evt, nbtn_evt;
  logic [3:0]        rn_q, rn_d;
  logic [3:0]        sum_q, sum_d;
  logic              load_player_q, load_player_d;
  logic              load_rn_q, load_rn_d;
  logic              round_active_q, round_active_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              timeout_hit;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, feedback enters at bit 0.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign pbtn_evt = bus.PlayerBtn & ~pbtn_q;
  assign nbtn_evt = bus.NextBtn & ~nbtn_q;

`ifdef ROUND_TIMEOUT_EN
  logic [23:0] timeout_q, timeout_d;

  assign timeout_hit = (state_q == StArmed) && (timeout_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == StArmed) begin
      timeout_d = timeout_q + 24'd1;
    end
    // Restart the budget whenever a new round is armed.
    if ((state_q == StIdle || state_q == StDone) && nbtn_evt) begin
      timeout_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rn_d           = rn_q;
    sum_d          = sum_q;
    load_player_d  = 1'b0;
    load_rn_d      = 1'b0;
    round_active_d = round_active_q;
    guard_d        = guard_q;

    unique case (state_q)
      StIdle, StDone: begin
        // RN takes the LFSR value seen this cycle, before the shift lands.
        if (nbtn_evt) begin
          rn_d           = lfsr_q[3:0];
          load_rn_d      = 1'b1;
          round_active_d = 1'b1;
          state_d        = StArmed;
        end
      end
      StArmed: begin
        // A real entry beats both NextBtn and a coincident timeout.
        if (pbtn_evt || timeout_hit) begin
          sum_d          = pbtn_evt ? (rn_q + bus.PlayerIn) : 4'h0;
          load_player_d  = 1'b1;
          round_active_d = 1'b0;
          guard_d        = '0;
          state_d        = StSettle;
        end
      end
      StSettle: begin
        if (guard_q == GuardLast) begin
          state_d = StDone;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
      default: begin
        state_d        = StIdle;
        round_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      lfsr_q         <= LFSR_SEED;
      pbtn_q         <= 1'b0;
      nbtn_q         <= 1'b0;
      rn_q           <= 4'h0;
      sum_q          <= 4'h0;
      load_player_q  <= 1'b0;
      load_rn_q      <= 1'b0;
      round_active_q <= 1'b0;
      guard_q        <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      pbtn_q         <= bus.PlayerBtn;
      nbtn_q         <= bus.NextBtn;
      rn_q           <= rn_d;
      sum_q          <= sum_d;
      load_player_q  <= load_player_d;
      load_rn_q      <= load_rn_d;
      round_active_q <= round_active_d;
      guard_q        <= guard_d;
    end
  end

  assign bus.RN          = rn_q;
  assign bus.sum         = sum_q;
  assign bus.LoadPlayer  = load_player_q;
  assign bus.LoadRN      = load_rn_q;
  assign bus.RoundActive = round_active_q;

endmodule
